// File: rtl/token_fifo_pkg.sv
// Shared helpers for the token FIFO reader: index wrap-around, popcount and
// the minimum synchronizer depth.
`timescale 1ns/1ps
package token_fifo_pkg;

    localparam int MIN_SYNC_STAGES = 2;
    localparam int POPCOUNT_MAX    = 64;

    // Wraps at depth-1 so non-power-of-two depths never index past the buffer.
    function automatic int idx_next(input int idx, input int depth);
        return (idx >= depth - 1) ? 0 : idx + 1;
    endfunction

    function automatic int popcount(input logic [POPCOUNT_MAX-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < POPCOUNT_MAX; i++) begin
            if (v[i]) n++;
        end
        return n;
    endfunction

endpackage

// File: rtl/token_fifo_reader_sync.sv
// Multi-stage bit synchronizer with asynchronous active-high reset; one chain
// per bit of a toggle-encoded token vector.
`timescale 1ns/1ps
module token_sync
    import token_fifo_pkg::*;
#(
    parameter int STAGES = 2,
    parameter int WIDTH  = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    localparam int N = (STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : STAGES;

    logic [N-1:0][WIDTH-1:0] sync_q;
    logic [N-1:0][WIDTH-1:0] sync_d;

    always_comb begin
        sync_d[0] = d_i;
        for (int s = 1; s < N; s++) begin
            sync_d[s] = sync_q[s-1];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) sync_q <= '0;
        else       sync_q <= sync_d;
    end

    assign q_o = sync_q[N-1];

endmodule

// File: rtl/token_fifo_reader.sv
// Read end of a token-based dual-clock channel: synchronizes write tokens,
// streams entries in order on valid/ready, and returns toggle-encoded read
// tokens. Define TOKEN_FIFO_READER_LEVEL_EN to add the registered level_o port.
`timescale 1ns/1ps
module token_fifo_reader
    import token_fifo_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int BUFFER_DEPTH = 8,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [BUFFER_DEPTH-1:0]            writetoken_i,
    input  logic [BUFFER_DEPTH*DATA_WIDTH-1:0] data_async_i,
    output logic [BUFFER_DEPTH-1:0]            readpointer_o,
    output logic                               valid_o,
    input  logic                               ready_i,
`ifdef TOKEN_FIFO_READER_LEVEL_EN
    output logic [$clog2(BUFFER_DEPTH+1)-1:0]  level_o,
`endif
    output logic [DATA_WIDTH-1:0]              data_o
);

    localparam int IDX_W = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;

    logic [BUFFER_DEPTH-1:0] wt_sync;

    token_sync #(
        .STAGES (SYNC_STAGES),
        .WIDTH  (BUFFER_DEPTH)
    ) u_wt_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (writetoken_i),
        .q_o   (wt_sync)
    );

    logic [IDX_W-1:0]        rd_idx_q, rd_idx_d;
    logic [BUFFER_DEPTH-1:0] readpointer_q, readpointer_d;
    logic                    valid_q, valid_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [DATA_WIDTH-1:0]   entry;
    logic                    avail;
    logic                    load;

    // Valid/ready: an entry transfers on any clk_i edge where valid_o && ready_i;
    // valid_o never drops and data_o never changes while valid_o && !ready_i.
    always_comb begin
        rd_idx_d      = rd_idx_q;
        readpointer_d = readpointer_q;
        valid_d       = valid_q;
        data_d        = data_q;

        entry = data_async_i[int'(rd_idx_q) * DATA_WIDTH +: DATA_WIDTH];
        avail = (wt_sync[rd_idx_q] != readpointer_q[rd_idx_q]);
        load  = avail && (!valid_q || ready_i);

        if (load) begin
            data_d                  = entry;
            valid_d                 = 1'b1;
            readpointer_d[rd_idx_q] = ~readpointer_q[rd_idx_q];
            rd_idx_d                = IDX_W'(idx_next(int'(rd_idx_q), BUFFER_DEPTH));
        end else if (ready_i && valid_q) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_idx_q      <= '0;
            readpointer_q <= '0;
            valid_q       <= 1'b0;
            data_q        <= '0;
        end else begin
            rd_idx_q      <= rd_idx_d;
            readpointer_q <= readpointer_d;
            valid_q       <= valid_d;
            data_q        <= data_d;
        end
    end

    assign readpointer_o = readpointer_q;
    assign valid_o       = valid_q;
    assign data_o        = data_q;

`ifdef TOKEN_FIFO_READER_LEVEL_EN
    localparam int LVL_W = $clog2(BUFFER_DEPTH+1);

    logic [LVL_W-1:0] level_q, level_d;

    // Counts synchronized entries not yet loaded; the one held in data_o is excluded.
    always_comb begin
        level_d = LVL_W'(popcount(POPCOUNT_MAX'(wt_sync ^ readpointer_q)));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) level_q <= '0;
        else       level_q <= level_d;
    end

    assign level_o = level_q;
`endif

endmodule

// File: tb/tb_token_fifo_reader.sv
// Self-checking bench for token_fifo_reader: writer model on a slower async
// clock, queue-based scoreboard, and directed latency/reset/boundary checks.
`timescale 1ns/1ps
module tb_token_fifo_reader;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int SS    = 2;

  // ---------------- clock / reset ----------------
  logic clk     = 1'b0;
  logic wclk    = 1'b0;
  logic rst_i   = 1'b1;
  logic ready_i = 1'b0;

  always #5 clk = ~clk;
  initial begin
    #3.35;
    forever #18.7 wclk = ~wclk;
  end

  logic [DEPTH-1:0]    writetoken_i;
  logic [DEPTH*DW-1:0] data_async_i;
  logic [DEPTH-1:0]    readpointer_o;
  logic                valid_o;
  logic [DW-1:0]       data_o;
`ifdef TOKEN_FIFO_READER_LEVEL_EN
  logic [3:0]          level_o;
`endif

  token_fifo_reader #(
    .DATA_WIDTH   (DW),
    .BUFFER_DEPTH (DEPTH),
    .SYNC_STAGES  (SS)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .writetoken_i  (writetoken_i),
    .data_async_i  (data_async_i),
    .readpointer_o (readpointer_o),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
`ifdef TOKEN_FIFO_READER_LEVEL_EN
    .level_o       (level_o),
`endif
    .data_o        (data_o)
  );

  // ---------------- bookkeeping ----------------
  int errors = 0;
  int checks = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] wr_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- writer side ----------------
  // Directed writes come from the main process; the paced writer model runs on wclk.
  logic                wr_auto  = 1'b0;
  logic [DEPTH-1:0]    dir_wt   = '0;
  logic [DEPTH*DW-1:0] dir_buf  = '0;
  logic [DEPTH-1:0]    auto_wt  = '0;
  logic [DEPTH*DW-1:0] auto_buf = '0;
  logic [DEPTH-1:0]    rp_s1    = '0;
  logic [DEPTH-1:0]    rp_s2    = '0;
  int                  w_idx    = 0;

  assign writetoken_i = wr_auto ? auto_wt  : dir_wt;
  assign data_async_i = wr_auto ? auto_buf : dir_buf;

  always @(posedge wclk or posedge rst_i) begin
    if (rst_i) begin
      auto_wt  = '0;
      auto_buf = '0;
      rp_s1    = '0;
      rp_s2    = '0;
      w_idx    = 0;
    end else begin
      rp_s2 = rp_s1;
      rp_s1 = readpointer_o;
      if (wr_auto && wr_q.size() != 0 && auto_wt[w_idx] == rp_s2[w_idx]
          && $urandom_range(0, 3) != 0) begin
        logic [DW-1:0] v;
        v = wr_q.pop_front();
        auto_buf[w_idx*DW +: DW] = v;
        exp_q.push_back(v);
        auto_wt[w_idx] = ~auto_wt[w_idx];
        w_idx = (w_idx + 1) % DEPTH;
      end
    end
  end

  task automatic dwrite(input int idx, input logic [DW-1:0] val);
    dir_buf[idx*DW +: DW] = val;
    dir_wt[idx] = ~dir_wt[idx];
    exp_q.push_back(val);
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic          hold_pending = 1'b0;
  logic [DW-1:0] hold_data    = '0;

  always @(negedge clk) begin
    if (rst_i) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) begin
        check("hold_valid", 32'(valid_o), 32'd1);
        check("hold_data", 32'(data_o), 32'(hold_data));
      end
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got data %0h, expected no output at %0t", data_o, $time);
        end else begin
          check("sb_data", 32'(data_o), 32'(exp_q.pop_front()));
        end
      end
      hold_pending = valid_o && !ready_i;
      hold_data    = data_o;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_i   = 1'b1;
    ready_i = 1'b0;
    wr_auto = 1'b0;
    dir_wt  = '0;
    dir_buf = '0;
    exp_q.delete();
    wr_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    rst_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic measure_latency(input string name);
    int n;
    n = 0;
    while (!valid_o && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, n, 32'd3);
  endtask

  task automatic wait_drain(input string name, input int budget, input bit rand_ready);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || wr_q.size() != 0 || valid_o) && n < budget) begin
      @(posedge clk);
      #1;
      if (rand_ready) ready_i = 1'($urandom_range(0, 1));
      n++;
    end
    check(name, 32'(n < budget), 32'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    // Reset values before any clock edge.
    #2;
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_rp", 32'(readpointer_o), 32'd0);
    check("rst_data", 32'(data_o), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    rst_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // First-entry latency.
    ready_i = 1'b1;
    @(negedge clk);
    #1;
    dwrite(0, 8'hA5);
    measure_latency("lat_first");
    check("first_data", 32'(data_o), 32'hA5);
    check("first_rp", 32'(readpointer_o), 32'h01);
    @(posedge clk);
    #1;
    check("first_empty", 32'(valid_o), 32'd0);

    // Fill all entries, back-pressure, then burst out with no bubble.
    do_reset();
    @(negedge clk);
    #1;
    for (int i = 0; i < DEPTH; i++) dwrite(i, DW'(i));
    repeat (20) @(posedge clk);
    #1;
    check("full_valid", 32'(valid_o), 32'd1);
    check("full_data", 32'(data_o), 32'h00);
    check("full_rp", 32'(readpointer_o), 32'h01);
    ready_i = 1'b1;
    for (int k = 1; k < DEPTH; k++) begin
      @(posedge clk);
      #1;
      check("burst_valid", 32'(valid_o), 32'd1);
      check("burst_data", 32'(data_o), 32'(k));
    end
    check("burst_rp", 32'(readpointer_o), 32'hFF);
    @(posedge clk);
    #1;
    check("burst_empty", 32'(valid_o), 32'd0);

    // Index wrap: 16 consumes restore the pointer, 4 more toggle the low half.
    do_reset();
    ready_i = 1'b1;
    wr_auto = 1'b1;
    for (int i = 0; i < 16; i++) wr_q.push_back(DW'($urandom_range(0, 255)));
    wait_drain("wrap16_drain", 3000, 1'b0);
    check("wrap16_rp", 32'(readpointer_o), 32'h00);
    for (int i = 0; i < 4; i++) wr_q.push_back(DW'($urandom_range(0, 255)));
    wait_drain("wrap20_drain", 1000, 1'b0);
    check("wrap20_rp", 32'(readpointer_o), 32'h0F);

    // Random ready and random writer pacing.
    do_reset();
    wr_auto = 1'b1;
    for (int i = 0; i < 4000; i++) wr_q.push_back(DW'($urandom_range(0, 255)));
    wait_drain("random_drain", 60000, 1'b1);
    ready_i = 1'b1;

    // Asynchronous reset with entries pending.
    do_reset();
    @(negedge clk);
    #1;
    dwrite(0, 8'h11);
    dwrite(1, 8'h22);
    dwrite(2, 8'h33);
    repeat (6) @(posedge clk);
    #1;
    check("pre_rst_valid", 32'(valid_o), 32'd1);
    @(posedge clk);
    #2;
    rst_i   = 1'b1;
    wr_auto = 1'b0;
    dir_wt  = '0;
    dir_buf = '0;
    exp_q.delete();
    #1;
    check("async_rst_valid", 32'(valid_o), 32'd0);
    check("async_rst_rp", 32'(readpointer_o), 32'd0);
    check("async_rst_data", 32'(data_o), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    rst_i   = 1'b0;
    ready_i = 1'b1;
    @(negedge clk);
    #1;
    dwrite(0, 8'h5A);
    measure_latency("lat_after_rst");
    check("after_rst_data", 32'(data_o), 32'h5A);
    wait_drain("after_rst_drain", 50, 1'b0);

`ifdef TOKEN_FIFO_READER_LEVEL_EN
    do_reset();
    @(negedge clk);
    #1;
    for (int i = 0; i < 5; i++) dwrite(i, DW'(8'h10 + i));
    repeat (10) @(posedge clk);
    #1;
    check("level_held", 32'(level_o), 32'd4);
    check("level_valid", 32'(valid_o), 32'd1);
    ready_i = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("level_empty", 32'(level_o), 32'd0);
    check("level_empty_valid", 32'(valid_o), 32'd0);
`endif

    check("sb_leftover", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
